// File: rtl/lsu_dbus.sv
// rtl/lsu_dbus.sv - memory-stage load/store unit driving a req/gnt/rvalid data bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module lsu_dbus (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        misalign_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        mis_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic is_mem(input logic [7:0] op);
    return is_load(op) || (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Lane steering for the op currently presented; captured on leaving IDLE.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = rt_data_i;
    case (aluop_i)
      EXE_SB_OP: begin
        be_c    = 4'b0001 << mem_addr_i[1:0];
        wdata_c = {4{rt_data_i[7:0]}};
      end
      EXE_SH_OP: begin
        be_c    = 4'b0011 << {mem_addr_i[1], 1'b0};
        wdata_c = {2{rt_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    mis_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (aluop_i)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: mis_c = mem_addr_i[0];
      EXE_LW_OP, EXE_SW_OP:             mis_c = |mem_addr_i[1:0];
      default:                          mis_c = 1'b0;
    endcase
`else
    mis_c = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 8'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (is_mem(aluop_i)) begin
          op_d    = aluop_i;
          addr_d  = mem_addr_i;
          be_d    = be_c;
          wdata_d = wdata_c;
          mis_d   = mis_c;
          state_d = mis_c ? DONE : REQ;
        end
      end
      REQ: begin
        if (dbus_gnt_i) state_d = is_load(op_q) ? WAIT_R : DONE;
      end
      WAIT_R: begin
        if (dbus_rvalid_i) begin
          rdata_d = dbus_rdata_i;
          state_d = DONE;
        end
      end
      DONE: begin
        mis_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_sel  = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = rdata_q[{addr_q[1], 4'b0000} +: 16];
    load_data = rdata_q;
    case (op_q)
      EXE_LB_OP:  load_data = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: load_data = {24'd0, byte_sel};
      EXE_LH_OP:  load_data = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: load_data = {16'd0, half_sel};
      default:    load_data = rdata_q;
    endcase
  end

  // Outputs are forced low during reset, including the IDLE pass-through path.
  always_comb begin
    reg_waddr_o  = 5'd0;
    reg_we_o     = 1'b0;
    reg_wdata_o  = 32'd0;
    stallreq_o   = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = 32'd0;
    dbus_be_o    = 4'd0;
    dbus_wdata_o = 32'd0;
    misalign_o   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (is_mem(aluop_i)) begin
            stallreq_o = 1'b1;
          end else begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
          end
        end
        REQ: begin
          stallreq_o   = 1'b1;
          dbus_req_o   = 1'b1;
          dbus_we_o    = !is_load(op_q);
          dbus_addr_o  = {addr_q[31:2], 2'b00};
          dbus_be_o    = be_q;
          dbus_wdata_o = wdata_q;
        end
        WAIT_R: stallreq_o = 1'b1;
        DONE: begin
          reg_waddr_o = reg_waddr_i;
          if (mis_q) begin
            misalign_o = 1'b1;
          end else if (is_load(op_q)) begin
            reg_we_o    = reg_we_i;
            reg_wdata_o = load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dbus.sv
// tb/tb_lsu_dbus.sv - directed self-checking bench for lsu_dbus with a programmable bus responder.
module tb_lsu_dbus;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;
  localparam logic [7:0] ADD = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop = ADD;
  logic [31:0] mem_addr = '0;
  logic [31:0] rt_data = '0;
  logic [4:0]  reg_waddr = '0;
  logic        reg_we = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_dbus dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop), .mem_addr_i(mem_addr), .rt_data_i(rt_data),
    .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .stallreq_o(stallreq_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid), .dbus_rdata_i(rdata),
    .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic nop(input logic [31:0] wd);
    @(posedge clk); #1;
    aluop = ADD; reg_wdata = wd; reg_waddr = 5'd4; reg_we = 1'b1;
    #1;
    chk("add wdata", reg_wdata_o, wd);
    chk("add we", {31'd0, reg_we_o}, 1);
    chk("add stall", {31'd0, stallreq_o}, 0);
    chk("add req", {31'd0, dbus_req_o}, 0);
  endtask

  // gw: REQ cycles before grant; rw: WAIT_R cycles before rvalid; early: rvalid with junk during REQ.
  task automatic run_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input int gw, input int rw, input logic [31:0] rd,
                         input logic early, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_we, input int e_stall,
                         input int e_req, input logic [31:0] e_res, input logic e_rwe,
                         input logic e_mis);
    int stall_n, req_n, wr_n, cyc;
    logic [31:0] c_addr, c_wd, c_res;
    logic [3:0] c_be;
    logic c_we, c_rwe, c_mis, unstable, granted, done;
    logic [4:0] c_waddr;
    stall_n = 0; req_n = 0; wr_n = 0; cyc = 0;
    c_addr = '0; c_wd = '0; c_res = '0; c_be = '0; c_we = 0; c_rwe = 0; c_mis = 0; c_waddr = '0;
    unstable = 0; granted = 0; done = 0;
    @(posedge clk); #1;
    aluop = op; mem_addr = addr; rt_data = rt; reg_waddr = 5'd9; reg_we = 1'b1; reg_wdata = 32'h1111_2222;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      if (stallreq_o) begin
        stall_n++;
        if (dbus_req_o) begin
          if (req_n == 0) begin
            c_addr = dbus_addr_o; c_be = dbus_be_o; c_wd = dbus_wdata_o; c_we = dbus_we_o;
          end else if (c_addr !== dbus_addr_o || c_be !== dbus_be_o ||
                       c_wd !== dbus_wdata_o || c_we !== dbus_we_o) begin
            unstable = 1;
          end
          if (req_n >= gw) begin gnt = 1'b1; granted = 1; end
          if (early) begin rvalid = 1'b1; rdata = 32'hBAD0_BAD0; end
          req_n++;
        end else if (granted) begin
          if (wr_n >= rw) begin rvalid = 1'b1; rdata = rd; end
          wr_n++;
        end
      end else begin
        done = 1;
        c_res = reg_wdata_o; c_rwe = reg_we_o; c_mis = misalign_o; c_waddr = reg_waddr_o;
      end
    end
    chk({tag, " completes"}, {31'd0, done}, 1);
    chk({tag, " stall cycles"}, stall_n, e_stall);
    chk({tag, " req cycles"}, req_n, e_req);
    chk({tag, " reg_we"}, {31'd0, c_rwe}, {31'd0, e_rwe});
    chk({tag, " misalign"}, {31'd0, c_mis}, {31'd0, e_mis});
    if (e_req != 0) begin
      chk({tag, " addr"}, c_addr, e_addr);
      chk({tag, " be"}, {28'd0, c_be}, {28'd0, e_be});
      chk({tag, " bus we"}, {31'd0, c_we}, {31'd0, e_we});
      chk({tag, " req stable"}, {31'd0, unstable}, 0);
      if (e_we) chk({tag, " bus wdata"}, c_wd, e_wd);
    end
    if (e_rwe) begin
      chk({tag, " result"}, c_res, e_res);
      chk({tag, " waddr"}, {27'd0, c_waddr}, 32'd9);
    end
  endtask

  initial begin
    aluop = ADD; reg_wdata = 32'hAB; reg_waddr = 5'd3; reg_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wdata", reg_wdata_o, 0);
    chk("reset we", {31'd0, reg_we_o}, 0);
    chk("reset waddr", {27'd0, reg_waddr_o}, 0);
    chk("reset stall", {31'd0, stallreq_o}, 0);
    chk("reset req", {31'd0, dbus_req_o}, 0);
    @(posedge clk); #1 rst = 1'b0;

    nop(32'h55);
    run_mem("lb", LB, 32'h103, 32'h0, 0, 0, 32'h80FF_FF7F, 0,
            32'h100, 4'b1111, 32'h0, 0, 3, 1, 32'hFFFF_FF80, 1, 0);
    run_mem("sh", SH, 32'h202, 32'h1234_ABCD, 0, 0, 32'h0, 0,
            32'h200, 4'b1100, 32'hABCD_ABCD, 1, 2, 1, 32'h0, 0, 0);
    run_mem("lhu", LHU, 32'h8, 32'h0, 3, 1, 32'h0000_9876, 0,
            32'h8, 4'b1111, 32'h0, 0, 7, 4, 32'h0000_9876, 1, 0);
    run_mem("sb", SB, 32'h101, 32'h0000_00A5, 0, 0, 32'h0, 0,
            32'h100, 4'b0010, 32'hA5A5_A5A5, 1, 2, 1, 32'h0, 0, 0);
    run_mem("lh", LH, 32'h2, 32'h0, 0, 0, 32'h8001_0000, 0,
            32'h0, 4'b1111, 32'h0, 0, 3, 1, 32'hFFFF_8001, 1, 0);
    run_mem("lbu", LBU, 32'h1, 32'h0, 0, 0, 32'h0000_F000, 0,
            32'h0, 4'b1111, 32'h0, 0, 3, 1, 32'h0000_00F0, 1, 0);
    run_mem("sw", SW, 32'h10, 32'hCAFE_F00D, 0, 0, 32'h0, 0,
            32'h10, 4'b1111, 32'hCAFE_F00D, 1, 2, 1, 32'h0, 0, 0);
    run_mem("lw early rvalid", LW, 32'hC, 32'h0, 1, 0, 32'h0BAD_CAFE, 1,
            32'hC, 4'b1111, 32'h0, 0, 4, 2, 32'h0BAD_CAFE, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_mem("lw mis", LW, 32'h6, 32'h0, 0, 0, 32'hDEAD_BEEF, 0,
            32'h0, 4'b0000, 32'h0, 0, 1, 0, 32'h0, 0, 1);
`else
    run_mem("lw mis", LW, 32'h6, 32'h0, 0, 0, 32'hDEAD_BEEF, 0,
            32'h4, 4'b1111, 32'h0, 0, 3, 1, 32'hDEAD_BEEF, 1, 0);
`endif

    @(posedge clk); #1;
    aluop = LW; mem_addr = 32'h10; reg_waddr = 5'd7; reg_we = 1'b1;
    @(negedge clk);
    chk("rst idle stall", {31'd0, stallreq_o}, 1);
    @(negedge clk);
    chk("rst req", {31'd0, dbus_req_o}, 1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("rst wait_r stall", {31'd0, stallreq_o}, 1);
    chk("rst wait_r req", {31'd0, dbus_req_o}, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst mid stall", {31'd0, stallreq_o}, 0);
    chk("rst mid req", {31'd0, dbus_req_o}, 0);
    chk("rst mid waddr", {27'd0, reg_waddr_o}, 0);
    chk("rst mid we", {31'd0, reg_we_o}, 0);
    chk("rst mid addr", dbus_addr_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; aluop = ADD; reg_wdata = 32'h77; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rvalid = 1'b0;
    chk("post rst stall", {31'd0, stallreq_o}, 0);
    chk("post rst passthru", reg_wdata_o, 32'h77);
    run_mem("lw after rst", LW, 32'h20, 32'h0, 0, 0, 32'h1357_9BDF, 0,
            32'h20, 4'b1111, 32'h0, 0, 3, 1, 32'h1357_9BDF, 1, 0);
    nop(32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
